// File: rtl/shift_bank_pkg.sv
// Shared types for the shift bank: channel operation codes, snapshot FSM
// states and a helper that sizes the channel-index field.
package shift_bank_pkg;

    typedef enum logic [1:0] {
        SHIFT_L = 2'd0,
        SHIFT_R = 2'd1,
        ROT_L   = 2'd2,
        LOAD    = 2'd3
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } snap_state_t;

    // Width of a channel index; a single-channel bank still gets one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_bank_if.sv
// Snapshot readout port of the shift bank.
//
// Handshake: the producer raises snap_valid with snap_data/snap_chan and
// holds all three stable until a cycle where snap_valid && snap_ready; that
// rising edge transfers the beat. snap_ready may be asserted at any time and
// never depends on snap_valid. snap_req is a level sampled only while idle.
interface shift_bank_if
    import shift_bank_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    localparam int CW = chan_w(CHANNELS);

    logic              snap_req;
    logic              snap_ready;
    logic              snap_valid;
    logic [WIDTH-1:0]  snap_data;
    logic [CW-1:0]     snap_chan;
    logic              snap_busy;
    snap_state_t       snap_state;

    modport master (
        input  snap_req, snap_ready,
        output snap_valid, snap_data, snap_chan, snap_busy, snap_state
    );

    modport slave (
        output snap_req, snap_ready,
        input  snap_valid, snap_data, snap_chan, snap_busy, snap_state
    );
endinterface

// File: rtl/shift_chan.sv
// One WIDTH-bit shift channel: shift-left, shift-right, rotate-left or
// parallel load when enabled, hold otherwise.
module shift_chan
    import shift_bank_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  mode_t            mode,
    input  logic             i,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);
    (* make_external = "output" *) logic [WIDTH-1:0] data;

    // Channel register: apply the selected operation only when enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= RESET_VAL;
        end else if (en) begin
            case (mode)
                SHIFT_L: data <= {data[WIDTH-2:0], i};
                SHIFT_R: data <= {i, data[WIDTH-1:1]};
                ROT_L:   data <= {data[WIDTH-2:0], data[WIDTH-1]};
                LOAD:    data <= load_val;
                default: data <= data;
            endcase
        end
    end

    assign q = data;
endmodule

// File: rtl/shift_bank.sv
// Bank of independent shift channels with a snapshot readout that streams
// a frozen copy of every channel, one beat per channel.
module shift_bank
    import shift_bank_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               CHANNELS  = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [1:0]                mode,
    input  logic [CHANNELS-1:0]       i,
    input  logic [CHANNELS*WIDTH-1:0] load_data,
    output logic [CHANNELS-1:0]       o_msb,
    output logic [CHANNELS-1:0]       o_lsb,
    shift_bank_if.master              snap
);
    localparam int            CW   = chan_w(CHANNELS);
    localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

    logic [WIDTH-1:0] chan_data [CHANNELS];
    logic [WIDTH-1:0] snap_buf  [CHANNELS];

    snap_state_t   state_q, state_d;
    logic [CW-1:0] chan_q, chan_d;
    logic          capture;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        shift_chan #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en[c]),
            .mode     (mode_t'(mode)),
            .i        (i[c]),
            .load_val (load_data[c*WIDTH +: WIDTH]),
            .q        (chan_data[c])
        );

        assign o_msb[c] = chan_data[c][WIDTH-1];
        assign o_lsb[c] = chan_data[c][0];
    end

    // Snapshot FSM state and beat index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
        end
    end

    // Next state: capture on request while idle, step through channels on accept.
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (snap.snap_req) begin
                    state_d = ST_SEND;
                    chan_d  = '0;
                    capture = 1'b1;
                end
            end
            ST_SEND: begin
                if (snap.snap_ready) begin
                    if (chan_q == LAST) begin
                        state_d = ST_IDLE;
                        chan_d  = '0;
                    end else begin
                        chan_d = chan_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                chan_d  = '0;
            end
        endcase
    end

    // Snapshot buffer: frozen copy of the pre-edge channel values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) snap_buf[c] <= '0;
        end else if (capture) begin
            for (int c = 0; c < CHANNELS; c++) snap_buf[c] <= chan_data[c];
        end
    end

    assign snap.snap_valid = (state_q == ST_SEND);
    assign snap.snap_busy  = (state_q == ST_SEND);
    assign snap.snap_chan  = chan_q;
    assign snap.snap_data  = snap_buf[chan_q];
    assign snap.snap_state = state_q;
endmodule

// File: tb/tb_shift_bank.sv
// Directed bench for shift_bank with WIDTH=8, CHANNELS=2.
module tb_shift_bank;
    import shift_bank_pkg::*;

    localparam int W = 8;
    localparam int N = 2;

    logic             clk;
    logic             rst;
    logic [N-1:0]     en;
    logic [1:0]       mode;
    logic [N-1:0]     i;
    logic [N*W-1:0]   load_data;
    logic [N-1:0]     o_msb;
    logic [N-1:0]     o_lsb;

    shift_bank_if #(.WIDTH(W), .CHANNELS(N)) sif ();

    shift_bank #(
        .WIDTH     (W),
        .CHANNELS  (N),
        .RESET_VAL (8'h00)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .i         (i),
        .load_data (load_data),
        .o_msb     (o_msb),
        .o_lsb     (o_lsb),
        .snap      (sif)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] e, input mode_t m, input logic [N-1:0] b);
        en   = e;
        mode = m;
        i    = b;
    endtask

    task automatic load(input logic [W-1:0] v1, input logic [W-1:0] v0, input logic [N-1:0] e);
        load_data = {v1, v0};
        drive(e, LOAD, '0);
        tick();
        en = '0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(sif.snap_valid), 32'd0);
        check({tag, "_busy"},  32'(sif.snap_busy),  32'd0);
    endtask

    task automatic check_beat(input string tag, input logic [0:0] ch);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check({tag, "_valid"}, 32'(sif.snap_valid), 32'd1);
        check({tag, "_chan"},  32'(sif.snap_chan),  32'(ch));
        check({tag, "_data"},  32'(sif.snap_data),  32'(e));
    endtask

    initial begin
        rst = 1'b1;
        en = '0; mode = 2'd0; i = '0; load_data = '0;
        sif.snap_req = 1'b0;
        sif.snap_ready = 1'b0;
        #2 rst = 1'b0;
        #10;
        check_idle("rst");
        check("rst_chan", 32'(sif.snap_chan), 32'd0);
        check("rst_ch0", 32'(u_dut.chan_data[0]), 32'h00);
        check("rst_ch1", 32'(u_dut.chan_data[1]), 32'h00);
        check("rst_msb", 32'(o_msb), 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // shift-left ones into ch0 only
        drive(2'b01, SHIFT_L, 2'b11);
        repeat (3) tick();
        en = '0;
        check("shl_ch0", 32'(u_dut.chan_data[0]), 32'h07);
        check("shl_ch1", 32'(u_dut.chan_data[1]), 32'h00);
        check("shl_lsb", 32'(o_lsb), 32'b01);
        check("shl_msb", 32'(o_msb), 32'b00);

        // load, rotate, shift-right
        load(8'h00, 8'h81, 2'b01);
        check("ld_ch0", 32'(u_dut.chan_data[0]), 32'h81);
        check("ld_msb", 32'(o_msb), 32'b01);
        drive(2'b01, ROT_L, 2'b00); tick();
        check("rot_ch0", 32'(u_dut.chan_data[0]), 32'h03);
        drive(2'b01, SHIFT_R, 2'b00); tick();
        check("shr_ch0", 32'(u_dut.chan_data[0]), 32'h01);

        // disabled channels hold in any mode
        load_data = {8'hFF, 8'hFF};
        drive(2'b00, LOAD, 2'b11); tick();
        check("hold_ch0", 32'(u_dut.chan_data[0]), 32'h01);
        check("hold_ch1", 32'(u_dut.chan_data[1]), 32'h00);

        // full snapshot with ready held high
        load(8'h3C, 8'hA5, 2'b11);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        sif.snap_ready = 1'b1;
        sif.snap_req = 1'b1; tick(); sif.snap_req = 1'b0;
        check("s1_busy", 32'(sif.snap_busy), 32'd1);
        check("s1_state", 32'(sif.snap_state), 32'(ST_SEND));
        check_beat("s1_b0", 1'b0);
        tick();
        check_beat("s1_b1", 1'b1);
        tick();
        check_idle("s1_end");

        // stalled snapshot while channels keep shifting
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        sif.snap_ready = 1'b0;
        sif.snap_req = 1'b1; tick(); sif.snap_req = 1'b0;
        drive(2'b11, SHIFT_L, 2'b11);
        for (int k = 0; k < 5; k++) begin
            sif.snap_req = (k == 2);
            tick();
            check("stall_valid", 32'(sif.snap_valid), 32'd1);
            check("stall_chan",  32'(sif.snap_chan),  32'd0);
            check("stall_data",  32'(sif.snap_data),  32'hA5);
        end
        sif.snap_req = 1'b0;
        en = '0;
        check("live_ch0", 32'(u_dut.chan_data[0]), 32'hBF);
        check("live_ch1", 32'(u_dut.chan_data[1]), 32'h9F);
        check_beat("s2_b0", 1'b0);
        sif.snap_ready = 1'b1;
        tick();
        check_beat("s2_b1", 1'b1);
        tick();
        check_idle("s2_end");
        repeat (3) begin
            tick();
            check("s2_noextra", 32'(sif.snap_valid), 32'd0);
        end

        // shift-right with i=1 on ch1 only
        drive(2'b10, SHIFT_R, 2'b10); tick(); en = '0;
        check("shr1_ch1", 32'(u_dut.chan_data[1]), 32'hCF);
        check("shr1_ch0", 32'(u_dut.chan_data[0]), 32'hBF);

        // reset in the middle of a readout
        load(8'h22, 8'h11, 2'b11);
        sif.snap_ready = 1'b0;
        sif.snap_req = 1'b1; tick(); sif.snap_req = 1'b0;
        check("ab_pre_valid", 32'(sif.snap_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_idle("ab_rst");
        check("ab_chan", 32'(sif.snap_chan), 32'd0);
        check("ab_ch0", 32'(u_dut.chan_data[0]), 32'h00);
        check("ab_ch1", 32'(u_dut.chan_data[1]), 32'h00);
        @(posedge clk); #1 rst = 1'b1;
        sif.snap_ready = 1'b1;
        repeat (3) begin
            tick();
            check("ab_nobeat", 32'(sif.snap_valid), 32'd0);
        end
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        sif.snap_req = 1'b1; tick(); sif.snap_req = 1'b0;
        check_beat("s3_b0", 1'b0);
        tick();
        check_beat("s3_b1", 1'b1);
        tick();
        check_idle("s3_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_bank.md
SHIFT_BANK -- requirements
Module: shift_bank

Interface
REQ-001 Parameter WIDTH, default 32, bit width of each channel's shift register (>=2).
REQ-002 Parameter CHANNELS, default 4, number of independent shift channels (>=1).
REQ-003 Parameter RESET_VAL, default 0 (WIDTH bits), value loaded into every channel on reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 en  input  CHANNELS  per-channel update enable.
REQ-007 mode  input  2  operation for all enabled channels: 0 shift-left, 1 shift-right, 2 rotate-left, 3 parallel load.
REQ-008 i  input  CHANNELS  per-channel serial input bit.
REQ-009 load_data  input  CHANNELS*WIDTH  parallel load value; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-010 o_msb  output  CHANNELS  bit WIDTH-1 of each channel register.
REQ-011 o_lsb  output  CHANNELS  bit 0 of each channel register.
REQ-012 snap_req  input  1  request to capture all channels for readout.
REQ-013 snap_valid  output  1  snapshot beat valid.
REQ-014 snap_ready  input  1  consumer accepts beat.
REQ-015 snap_data  output  WIDTH  captured value of channel snap_chan.
REQ-016 snap_chan  output  $clog2(CHANNELS) (min 1)  channel index of current beat.
REQ-017 snap_busy  output  1  high while a snapshot readout is in progress.

Function
REQ-018 Enabled channel, mode 0: data <= {data[WIDTH-2:0], i[c]}; mode 1: data <= {i[c], data[WIDTH-1:1]}; mode 2: data <= {data[WIDTH-2:0], data[WIDTH-1]}; mode 3: data <= load_data slice c.
REQ-019 Channel with en[c]=0 holds its value regardless of mode.
REQ-020 o_msb/o_lsb are combinational from the channel registers (zero added latency).
REQ-021 Snapshot FSM states: IDLE, SEND.
REQ-022 IDLE: snap_valid=0, snap_busy=0; snap_req=1 captures every channel's register value as present before that edge into a snapshot buffer and moves to SEND with snap_chan=0.
REQ-023 SEND: snap_valid=1, snap_busy=1, snap_data = buffer[snap_chan]; snap_data and snap_chan stable until snap_valid&snap_ready.
REQ-024 On accept with snap_chan<CHANNELS-1, snap_chan increments next cycle; on accept of channel CHANNELS-1, FSM returns to IDLE (snap_valid low next cycle).
REQ-025 snap_req while in SEND is ignored (not queued); a new request is honoured only in IDLE.
REQ-026 Shift operations continue unaffected during SEND; buffer contents do not track live registers.
REQ-027 Readout of a full snapshot with snap_ready held high takes exactly CHANNELS cycles of snap_valid.

Reset
REQ-028 rst low asynchronously sets every channel to RESET_VAL, FSM to IDLE, snap_chan to 0, snap_valid and snap_busy to 0, buffer to 0.
REQ-029 Reset asserted mid-readout aborts the snapshot; no beat is emitted after reset release until a new snap_req.

Structure
REQ-030 Mode encodings (SHIFT_L, SHIFT_R, ROT_L, LOAD) and FSM state encodings reside in the shared package shift_bank_pkg.
REQ-031 One sub-module, shift_chan, implements a single WIDTH-bit channel (en, mode, i, load value), instantiated CHANNELS times by generate.
REQ-032 Each channel data register in shift_chan carries the attribute make_external = "output".

Verification
REQ-033 WIDTH=8, CHANNELS=2: reset, mode 0, en=2'b01, i=1 for 3 cycles -> ch0=8'h07, ch1=RESET_VAL, o_lsb[0]=1.
REQ-034 Load ch0=8'h81, then mode 2 one cycle -> ch0=8'h03; mode 1 with i=0 one cycle -> ch0=8'h01.
REQ-035 Load ch0=8'hA5, ch1=8'h3C; snap_req pulse, snap_ready=1 -> beats (0,8'hA5),(1,8'h3C) on 2 consecutive cycles, then snap_valid=0.
REQ-036 Snapshot with snap_ready=0 for 5 cycles while channels keep shifting -> snap_data stays 8'hA5, snap_chan stays 0; second snap_req during SEND produces no extra beats.
REQ-037 Assert rst during beat 0 of readout -> snap_valid=0, snap_busy=0, channels=RESET_VAL immediately; after release, no beats until new snap_req.
